// File: rtl/lsu_dm.sv
// Load/store unit in front of a single-port word-addressed data memory.
// Optional LSU_STATS_EN adds saturating load/store/error completion counters.
module lsu_dm #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [DATA_W-1:0] dm_wd,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rd
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_errs
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dm_wd_q, dm_wd_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic                accept;
  logic                req_bad;
  logic [4:0]          lane_sh;
  logic [DATA_W-1:0]   lane_mask;
  logic [DATA_W-1:0]   rd_shifted;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   merged;

  assign accept  = req_valid && (state_q == IDLE);
  assign req_bad = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_bad)                               state_d = RESP;
          else if (!req_we || (req_size != 2'b10))   state_d = READ;
          else                                       state_d = WRITE;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane handling: word accesses are aligned, so the shift is zero for them.
  always_comb begin
    lane_sh    = {addr_q[1:0], 3'b000};
    lane_mask  = ((size_q == 2'b00) ? DATA_W'(8'hFF) : DATA_W'(16'hFFFF)) << lane_sh;
    rd_shifted = dm_rd >> lane_sh;
    merged     = (dm_rd & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
    case (size_q)
      2'b00:   load_val = uns_q ? DATA_W'(rd_shifted[7:0])
                                : {{(DATA_W-8){rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_val = uns_q ? DATA_W'(rd_shifted[15:0])
                                : {{(DATA_W-16){rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_val = dm_rd;
    endcase
  end

  always_comb begin
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dm_wd_d      = dm_wd_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_bad) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else if (req_we && (req_size == 2'b10)) begin
            dm_wd_d = req_wdata;
          end
        end
      end
      READ: begin
        if (we_q) begin
          dm_wd_d = merged;
        end else begin
          resp_rdata_d = load_val;
          resp_err_d   = 1'b0;
        end
      end
      WRITE: begin
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      dm_wd_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dm_wd_q      <= dm_wd_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dm_addr    = addr_q[ADDR_W-1:2];
  assign dm_wd      = dm_wd_q;
  assign dm_we      = (state_q == WRITE) && !rst;

`ifdef LSU_STATS_EN
  logic [15:0] stat_loads_q, stat_loads_d;
  logic [15:0] stat_stores_q, stat_stores_d;
  logic [15:0] stat_errs_q, stat_errs_d;

  always_comb begin
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_errs_d   = stat_errs_q;
    if (state_q == RESP) begin
      if (resp_err_q) begin
        if (stat_errs_q != '1) stat_errs_d = stat_errs_q + 16'd1;
      end else if (we_q) begin
        if (stat_stores_q != '1) stat_stores_d = stat_stores_q + 16'd1;
      end else begin
        if (stat_loads_q != '1) stat_loads_d = stat_loads_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_lsu_dm.sv
// Bench for lsu_dm: byte-array reference memory, directed plan steps, then random traffic.
module tb_lsu_dm;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err, dm_we;
  logic [31:0] resp_rdata, dm_wd, dm_rd;
  logic [4:0]  dm_addr;
`ifdef LSU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
  int          n_loads = 0, n_stores = 0, n_errs = 0;
`endif

  always #5 clk = ~clk;

  lsu_dm #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we),
    .dm_rd(dm_rd)
`ifdef LSU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  logic [31:0] dm_mem [32];
  assign dm_rd = dm_mem[dm_addr];
  always @(posedge clk) if (dm_we) dm_mem[dm_addr] <= dm_wd;

  logic [7:0] ref_b [128];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  // Reference: byte-granular memory, little-endian assembly of loaded bytes.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input int a, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata,
                       output int lat, output int nwr);
    int nbytes;
    nbytes = 1 << size;
    err = (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
    rdata = 32'd0;
    if (err) begin
      lat = 1; nwr = 0;
    end else if (!we) begin
      for (int i = 0; i < nbytes; i++) rdata = rdata + (32'(ref_b[a+i]) << (8*i));
      if (!uns && nbytes < 4 && rdata[8*nbytes-1]) rdata = rdata | (32'hFFFF_FFFF << (8*nbytes));
      lat = 2; nwr = 0;
    end else begin
      for (int i = 0; i < nbytes; i++) ref_b[a+i] = 8'((wdata >> (8*i)) & 32'hFF);
      lat = (nbytes == 4) ? 2 : 3; nwr = 1;
    end
`ifdef LSU_STATS_EN
    if (err) n_errs++; else if (we) n_stores++; else n_loads++;
`endif
  endtask

  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [6:0] addr, input logic [31:0] wdata, input string tag);
    logic e_err; logic [31:0] e_rd, e_word; int e_lat, e_nwr, nw; bit got;
    model(we, size, uns, int'(addr), wdata, e_err, e_rd, e_lat, e_nwr);
    e_word = ref_word(int'(addr) / 4);
    nw = 0; got = 0;
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (dm_we) begin
        nw++;
        check({tag, ".dm_addr"}, {27'd0, dm_addr}, 32'(addr) >> 2);
        check({tag, ".dm_wd"}, dm_wd, e_word);
      end
      if (resp_valid) begin
        got = 1;
        check({tag, ".latency"}, k, e_lat);
        check({tag, ".err"}, {31'd0, resp_err}, {31'd0, e_err});
        check({tag, ".rdata"}, resp_rdata, e_rd);
      end else begin
        check({tag, ".busy_ready"}, {31'd0, req_ready}, 32'd0);
      end
    end
    if (!got) check({tag, ".timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
    check({tag, ".hold"}, resp_rdata, e_rd);
    check({tag, ".nwrites"}, nw, e_nwr);
  endtask

  initial begin
    logic        e_err;
    logic [31:0] e_a, e_b;
    int          lat, nwr;
    logic [1:0]  sz;
    logic [6:0]  ad;
    for (int i = 0; i < 32; i++) begin
      dm_mem[i] = $urandom;
      for (int j = 0; j < 4; j++) ref_b[4*i+j] = 8'(dm_mem[i] >> (8*j));
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", {31'd0, req_ready}, 32'd1);
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.resp_err", {31'd0, resp_err}, 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.dm_addr", {27'd0, dm_addr}, 32'd0);
    check("rst.dm_wd", dm_wd, 32'd0);
    check("rst.dm_we", {31'd0, dm_we}, 32'd0);
    rst = 1'b0;

    txn(1'b1, 2'd2, 1'b0, 7'h04, 32'hDEADBEEF, "sw");
    txn(1'b0, 2'd2, 1'b0, 7'h04, 32'h0, "lw");
    check("lw.plan", ref_word(1), 32'hDEADBEEF);
    txn(1'b1, 2'd0, 1'b0, 7'h06, 32'h000000A5, "sb");
    txn(1'b0, 2'd0, 1'b0, 7'h06, 32'h0, "lb");
    txn(1'b0, 2'd0, 1'b1, 7'h06, 32'h0, "lbu");
    txn(1'b1, 2'd1, 1'b0, 7'h04, 32'h00001234, "sh");
    check("sh.dm", dm_mem[1], 32'hDEA51234);
    txn(1'b0, 2'd1, 1'b0, 7'h06, 32'h0, "lh");
    txn(1'b0, 2'd1, 1'b1, 7'h06, 32'h0, "lhu");
    txn(1'b0, 2'd1, 1'b0, 7'h05, 32'h0, "err_lh");
    txn(1'b1, 2'd2, 1'b0, 7'h02, 32'h11223344, "err_sw");
    txn(1'b0, 2'd3, 1'b0, 7'h00, 32'h0, "err_size");

    // Reset landing in the WRITE cycle of a byte store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 7'h08; req_wdata = 32'hFF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rstw.dm_we", {31'd0, dm_we}, 32'd0);
    check("rstw.resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstw.ready", {31'd0, req_ready}, 32'd1);
    check("rstw.dm", dm_mem[2], ref_word(2));
    repeat (3) begin
      @(negedge clk);
      check("rstw.no_resp", {31'd0, resp_valid}, 32'd0);
    end
`ifdef LSU_STATS_EN
    n_loads = 0; n_stores = 0; n_errs = 0;
`endif

    // Back-to-back loads with req_valid held high.
    model(1'b0, 2'd2, 1'b0, 4, 32'h0, e_err, e_a, lat, nwr);
    model(1'b0, 2'd0, 1'b0, 6, 32'h0, e_err, e_b, lat, nwr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 7'h04;
    @(posedge clk); #1 req_size = 2'd0; req_addr = 7'h06;
    @(negedge clk); check("b2b.busy1", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("b2b.resp_a", {31'd0, resp_valid}, 32'd1);
    check("b2b.rdata_a", resp_rdata, e_a);
    check("b2b.busy2", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("b2b.idle", {31'd0, req_ready}, 32'd1);
    check("b2b.gap", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); check("b2b.busy3", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("b2b.resp_b", {31'd0, resp_valid}, 32'd1);
    check("b2b.rdata_b", resp_rdata, e_b);

    for (int n = 0; n < 200; n++) begin
      sz = 2'($urandom_range(0, 3));
      ad = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 4) != 0 && sz != 2'd3) ad = ad & ~7'((1 << sz) - 1);
      txn(1'($urandom), sz, 1'($urandom), ad, $urandom, "rnd");
    end
    for (int i = 0; i < 32; i++) check("final.mem", dm_mem[i], ref_word(i));
`ifdef LSU_STATS_EN
    check("stat.loads", {16'd0, stat_loads}, 32'(n_loads));
    check("stat.stores", {16'd0, stat_stores}, 32'(n_stores));
    check("stat.errs", {16'd0, stat_errs}, 32'(n_errs));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
